aes_round_ctrl: RTL and testbench

Round sequencer for the AES-128 encryption core. Accepts a start request, then walks the ADD_ROUND_KEY, SUB_BYTES, SHIFT_ROWS, MIX_COLUMNS and key-expansion units through the initial round, rounds 1–9 and the final round. It does this by pulsing each unit's enable and waiting for that unit's done pulse. It holds no datapath state; it only issues enables, mux selects and the round index, and reports completion or a stall error.

---
 rtl/aes_round_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Round sequencer for the AES-128 encryption core. After a start request it
// walks ADD_ROUND_KEY, SUB_BYTES, SHIFT_ROWS, MIX_COLUMNS and key expansion
// through the initial round, rounds 1-9 and the final round (no MIX_COLUMNS).
// Each stage is one enable pulse followed by a wait for that unit's done
// pulse. A stage that never answers within TIMEOUT wait cycles aborts the
// operation with an err pulse. No datapath state is held here.
//
// Parameters:
//   TIMEOUT   max wait cycles after an enable before aborting (1..255)
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start                     operation request, sampled only while idle
//   ark_done .. ke_done       per-unit done pulses
//   ark_en .. ke_en           per-unit one-cycle enables
//   ark_sel[1:0]              ADD_ROUND_KEY source: 0 plaintext, 1 MIX_COLUMNS,
//                             2 SHIFT_ROWS
//   round[3:0]                current round 0..10 (also rcon index)
//   busy                      operation in progress
//   done                      one-cycle pulse, ciphertext valid
//   err                       one-cycle pulse, stage timeout
//
// All outputs are registered; they are computed from the next-state values
// so that e.g. ark_en is high in the cycle right after start is sampled.
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       ark_done,
   input  logic       sb_done,
   input  logic       sr_done,
   input  logic       mc_done,
   input  logic       ke_done,
   output logic       ark_en,
   output logic       sb_en,
   output logic       sr_en,
   output logic       mc_en,
   output logic       ke_en,
   output logic [1:0] ark_sel,
   output logic [3:0] round,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
   localparam logic [3:0] LastRound  = 4'd10;

   typedef enum logic [3:0] {
      StIdle,
      StArk0,
      StSb,
      StSr,
      StMc,
      StKe,
      StArk,
      StFin,
      StErr
   } state_e;

   // Control state
   state_e     state_q, state_d;
   logic       issue_q, issue_d;   // 1: issue cycle of the current stage
   logic [7:0] cnt_q, cnt_d;       // wait cycles elapsed in the current stage
   logic [3:0] round_q, round_d;

   // Registered outputs
   logic       ark_en_q, ark_en_d;
   logic       sb_en_q, sb_en_d;
   logic       sr_en_q, sr_en_d;
   logic       mc_en_q, mc_en_d;
   logic       ke_en_q, ke_en_d;
   logic [1:0] ark_sel_q, ark_sel_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   // Stage helpers
   logic       stage_done;
   state_e     next_stage;
   logic [3:0] next_round;
   logic [7:0] cnt_inc;

   assign cnt_inc = cnt_q + 8'd1;

   // Only the done input belonging to the active stage is honoured.
   always_comb begin
      stage_done = 1'b0;
      unique case (state_q)
         StArk0, StArk: stage_done = ark_done;
         StSb:          stage_done = sb_done;
         StSr:          stage_done = sr_done;
         StMc:          stage_done = mc_done;
         StKe:          stage_done = ke_done;
         default:       stage_done = 1'b0;
      endcase
   end

   // Successor stage and round once the active stage completes.
   always_comb begin
      next_stage = StIdle;
      next_round = round_q;
      unique case (state_q)
         StArk0: begin
            next_stage = StSb;
            next_round = 4'd1;
         end
         StSb: next_stage = StSr;
         // The final round skips MIX_COLUMNS.
         StSr: next_stage = (round_q == LastRound) ? StKe : StMc;
         StMc: next_stage = StKe;
         StKe: next_stage = StArk;
         StArk: begin
            if (round_q == LastRound) begin
               next_stage = StFin;
            end else begin
               next_stage = StSb;
               next_round = round_q + 4'd1;
            end
         end
         default: begin
            next_stage = StIdle;
            next_round = round_q;
         end
      endcase
   end

   // Main next-state logic.
   always_comb begin
      state_d = state_q;
      issue_d = 1'b0;
      cnt_d   = cnt_q;
      round_d = round_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (start) begin
               state_d = StArk0;
               issue_d = 1'b1;
               round_d = '0;
            end
         end
         StArk0, StSb, StSr, StMc, StKe, StArk: begin
            if (issue_q) begin
               // Done inputs seen during the issue cycle are ignored.
               cnt_d = '0;
            end else if (stage_done) begin
               state_d = next_stage;
               round_d = next_round;
               issue_d = (next_stage != StFin);
               cnt_d   = '0;
            end else if (cnt_inc == TimeoutCnt) begin
               state_d = StErr;
               round_d = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StFin, StErr: begin
            state_d = StIdle;
            round_d = '0;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            round_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output values for the cycle following this edge.
   always_comb begin
      ark_en_d  = issue_d && ((state_d == StArk0) || (state_d == StArk));
      sb_en_d   = issue_d && (state_d == StSb);
      sr_en_d   = issue_d && (state_d == StSr);
      mc_en_d   = issue_d && (state_d == StMc);
      ke_en_d   = issue_d && (state_d == StKe);
      busy_d    = !(state_d inside {StIdle, StFin, StErr});
      done_d    = (state_d == StFin);
      err_d     = (state_d == StErr);
      ark_sel_d = 2'd0;
      unique case (state_d)
         StArk:   ark_sel_d = (round_d == LastRound) ? 2'd2 : 2'd1;
         // Keep the final-round source selected while the ciphertext is valid.
         StFin:   ark_sel_d = 2'd2;
         default: ark_sel_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         issue_q   <= 1'b0;
         cnt_q     <= '0;
         round_q   <= '0;
         ark_en_q  <= 1'b0;
         sb_en_q   <= 1'b0;
         sr_en_q   <= 1'b0;
         mc_en_q   <= 1'b0;
         ke_en_q   <= 1'b0;
         ark_sel_q <= 2'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         issue_q   <= issue_d;
         cnt_q     <= cnt_d;
         round_q   <= round_d;
         ark_en_q  <= ark_en_d;
         sb_en_q   <= sb_en_d;
         sr_en_q   <= sr_en_d;
         mc_en_q   <= mc_en_d;
         ke_en_q   <= ke_en_d;
         ark_sel_q <= ark_sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign ark_en  = ark_en_q;
   assign sb_en   = sb_en_q;
   assign sr_en   = sr_en_q;
   assign mc_en   = mc_en_q;
   assign ke_en   = ke_en_q;
   assign ark_sel = ark_sel_q;
   assign round   = round_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Directed bench for aes_round_ctrl. Unit responders echo each enable as a
// done pulse after a configurable delay; one stage per run may be slowed or
// left unanswered. Expected stage order, issue cycles, rounds and ark_sel are
// derived from an independent schedule model. Cycle c is the clock period
// whose closing edge is c edges after the one that samples start at c=0.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

   localparam int unsigned TIMEOUT = 16;
   localparam int UArk = 0;
   localparam int USb  = 1;
   localparam int USr  = 2;
   localparam int UMc  = 3;
   localparam int UKe  = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       ark_done, sb_done, sr_done, mc_done, ke_done;
   logic       ark_en, sb_en, sr_en, mc_en, ke_en;
   logic [1:0] ark_sel;
   logic [3:0] round;
   logic       busy, done, err;

   int n_cmp = 0;
   int n_bad = 0;

   int rec_unit[$], rec_cyc[$], rec_round[$], rec_sel[$];
   int exp_unit[$], exp_cyc[$], exp_round[$], exp_sel[$];
   int exp_done, exp_err;
   int done_cyc, err_cyc, done_cnt, err_cnt, both_cnt, multi_cnt;
   int busy_first, busy_n, err_busy, err_round, mc10_cnt;

   aes_round_ctrl #(
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .ark_done (ark_done),
      .sb_done  (sb_done),
      .sr_done  (sr_done),
      .mc_done  (mc_done),
      .ke_done  (ke_done),
      .ark_en   (ark_en),
      .sb_en    (sb_en),
      .sr_en    (sr_en),
      .mc_en    (mc_en),
      .ke_en    (ke_en),
      .ark_sel  (ark_sel),
      .round    (round),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, $signed(act), $signed(exp));
      end
   endtask

   // Schedule model: issue times follow issue[i+1] = issue[i] + k + 1.
   // d_k = 0 means the selected stage never answers.
   task automatic build_exp(input int d_unit, input int d_round, input int d_k);
      int cyc;
      int k;
      int units[$];
      exp_unit.delete();
      exp_cyc.delete();
      exp_round.delete();
      exp_sel.delete();
      exp_done = -1;
      exp_err  = -1;
      exp_unit.push_back(UArk);
      exp_cyc.push_back(1);
      exp_round.push_back(0);
      exp_sel.push_back(0);
      cyc = 3;
      for (int r = 1; r <= 10; r++) begin
         units = {USb, USr};
         if (r < 10) units.push_back(UMc);
         units.push_back(UKe);
         units.push_back(UArk);
         foreach (units[j]) begin
            exp_unit.push_back(units[j]);
            exp_cyc.push_back(cyc);
            exp_round.push_back(r);
            exp_sel.push_back((r == 10) ? 2 : 1);
            k = (units[j] == d_unit && r == d_round) ? d_k : 1;
            if (k == 0) begin
               exp_err = cyc + TIMEOUT + 1;
               return;
            end
            cyc += k + 1;
         end
      end
      exp_done = cyc;
   endtask

   // One operation from start; entered and left at posedge+1.
   task automatic run_op(input int d_unit, input int d_round, input int d_k, input bit spur,
                         input int rst_cyc);
      int pend[5];
      int spur_sb;
      int end_c;
      int k;
      int u;
      int n_en;
      foreach (pend[i]) pend[i] = -1;
      spur_sb = -1;
      end_c   = -1;
      rec_unit.delete();
      rec_cyc.delete();
      rec_round.delete();
      rec_sel.delete();
      done_cyc = -1; err_cyc = -1; done_cnt = 0; err_cnt = 0; both_cnt = 0; multi_cnt = 0;
      busy_first = -1; busy_n = 0; err_busy = -1; err_round = -1; mc10_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         start    = (c == 0) || (spur && c == 40);
         ark_done = (pend[UArk] == c);
         sb_done  = (pend[USb] == c) || (spur_sb == c);
         sr_done  = (pend[USr] == c);
         mc_done  = (pend[UMc] == c);
         ke_done  = (pend[UKe] == c);
         if (c == rst_cyc) begin
            #2 rst_n = 1'b0;
            #1;
            check_eq("rst_async_en", {27'd0, ark_en, sb_en, sr_en, mc_en, ke_en}, 32'd0);
            check_eq("rst_async_sel", {30'd0, ark_sel}, 32'd0);
            check_eq("rst_async_round", {28'd0, round}, 32'd0);
            check_eq("rst_async_flags", {29'd0, busy, done, err}, 32'd0);
            start = 1'b0;
            {ark_done, sb_done, sr_done, mc_done, ke_done} = '0;
            return;
         end
         #4;
         n_en = int'(ark_en) + int'(sb_en) + int'(sr_en) + int'(mc_en) + int'(ke_en);
         if (n_en > 1) multi_cnt++;
         if (done && err) both_cnt++;
         if (busy) begin
            if (busy_first < 0) busy_first = c;
            busy_n++;
         end
         if (n_en == 1) begin
            u = ark_en ? UArk : sb_en ? USb : sr_en ? USr : mc_en ? UMc : UKe;
            rec_unit.push_back(u);
            rec_cyc.push_back(c);
            rec_round.push_back(int'(round));
            rec_sel.push_back(int'(ark_sel));
            if (u == UMc && round == 4'd10) mc10_cnt++;
            k = (u == d_unit && int'(round) == d_round) ? d_k : 1;
            pend[u] = (k == 0) ? -1 : c + k;
            if (spur && u == USr && int'(round) == d_round) spur_sb = c + 1;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (err) begin
            err_cnt++;
            if (err_cyc < 0) begin
               err_cyc   = c;
               err_busy  = int'(busy);
               err_round = int'(round);
            end
         end
         if (end_c < 0 && (done || err)) end_c = c;
         @(posedge clk);
         #1;
         if (end_c >= 0 && c >= end_c + 2) break;
      end
      start = 1'b0;
      {ark_done, sb_done, sr_done, mc_done, ke_done} = '0;
   endtask

   task automatic check_run(input string tag);
      int end_exp;
      check_eq({tag, "_nstage"}, rec_unit.size(), exp_unit.size());
      for (int i = 0; i < rec_unit.size() && i < exp_unit.size(); i++) begin
         check_eq($sformatf("%s_unit%0d", tag, i), rec_unit[i], exp_unit[i]);
         check_eq($sformatf("%s_cyc%0d", tag, i), rec_cyc[i], exp_cyc[i]);
         check_eq($sformatf("%s_round%0d", tag, i), rec_round[i], exp_round[i]);
         if (exp_unit[i] == UArk)
            check_eq($sformatf("%s_sel%0d", tag, i), rec_sel[i], exp_sel[i]);
      end
      check_eq({tag, "_done_cyc"}, done_cyc, exp_done);
      check_eq({tag, "_err_cyc"}, err_cyc, exp_err);
      check_eq({tag, "_done_cnt"}, done_cnt, (exp_done >= 0) ? 1 : 0);
      check_eq({tag, "_err_cnt"}, err_cnt, (exp_err >= 0) ? 1 : 0);
      check_eq({tag, "_multi_en"}, multi_cnt, 0);
      check_eq({tag, "_done_and_err"}, both_cnt, 0);
      check_eq({tag, "_mc_in_r10"}, mc10_cnt, 0);
      check_eq({tag, "_busy_first"}, busy_first, 1);
      end_exp = (exp_done >= 0) ? exp_done : exp_err;
      check_eq({tag, "_busy_cycles"}, busy_n, end_exp - 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      {ark_done, sb_done, sr_done, mc_done, ke_done} = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_en", {27'd0, ark_en, sb_en, sr_en, mc_en, ke_en}, 32'd0);
      check_eq("reset_sel", {30'd0, ark_sel}, 32'd0);
      check_eq("reset_round", {28'd0, round}, 32'd0);
      check_eq("reset_flags", {29'd0, busy, done, err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ark_done while idle must not start anything.
      ark_done = 1'b1;
      @(posedge clk);
      #1;
      ark_done = 1'b0;
      check_eq("idle_ark_done_en", {27'd0, ark_en, sb_en, sr_en, mc_en, ke_en}, 32'd0);
      check_eq("idle_ark_done_flags", {29'd0, busy, done, err}, 32'd0);
      @(posedge clk);
      #1;

      build_exp(-1, -1, 1);
      run_op(-1, -1, 1, 1'b0, -1);
      check_run("nominal");

      build_exp(UMc, 3, 5);
      run_op(UMc, 3, 5, 1'b0, -1);
      check_run("slow_mc");

      build_exp(USr, 2, 0);
      run_op(USr, 2, 0, 1'b0, -1);
      check_run("timeout");
      check_eq("timeout_err_busy", err_busy, 0);
      check_eq("timeout_err_round", err_round, 0);

      build_exp(-1, -1, 1);
      run_op(-1, -1, 1, 1'b0, -1);
      check_run("after_timeout");

      // Late SR answer with a stray sb_done in the SR wait and a start at 40.
      build_exp(USr, 5, 3);
      run_op(USr, 5, 3, 1'b1, -1);
      check_run("spurious");

      run_op(-1, -1, 1, 1'b0, 57);
      repeat (3) begin
         @(negedge clk);
         check_eq("in_reset_flags", {29'd0, busy, done, err}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      build_exp(-1, -1, 1);
      run_op(-1, -1, 1, 1'b0, -1);
      check_run("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
